string_char_sequencer: RTL and testbench

Sequences a packed Verilog string register (the 8*N-bit `reg` strings used across our string exercises) out one character per handshake. Downstream consumers are character sinks such as a display/UART model. Characters leave in reading order, first character first, over a valid/ready interface. The block captures a snapshot on start, so the source register may change while a string is being sent.

---
 rtl/string_char_sequencer.sv | 109 ++++++++++
 tb/tb_string_char_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/string_char_sequencer.sv
// string_char_sequencer: snapshots a packed string on start and emits it one character per valid/ready handshake.
// Optional ESCAPE_DOUBLE_EN: '%' and '\' are each sent as two handshakes of the same byte.
module string_char_sequencer #(
    parameter int MAX_CHARS = 40,
    parameter int LEN_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*MAX_CHARS-1:0] str_in,
    input  logic [LEN_W-1:0]       str_len,
    output logic                   busy,
    output logic [7:0]             ch_out,
    output logic                   ch_valid,
    input  logic                   ch_ready,
    output logic                   done,
    output logic                   err
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_CHARS);
    state_t state, state_n;
    logic [MAX_CHARS-1:0][7:0] shadow, shadow_n, str_b;
    logic [LEN_W-1:0] idx, idx_n, len_m1, idx_m1;
    logic [7:0] ch_out_n;
    logic busy_n, ch_valid_n, done_n, err_n, repeat_ch;
    assign str_b  = str_in;
    assign len_m1 = str_len - 1'b1;
    assign idx_m1 = idx - 1'b1;
`ifdef ESCAPE_DOUBLE_EN
    logic dup, dup_n;
    // First copy of an escape byte holds the character; the second copy advances.
    assign repeat_ch = !dup && (ch_out == 8'h25 || ch_out == 8'h5C);
    always_comb dup_n = (state == SEND && ch_ready) ? repeat_ch : dup;
    always_ff @(posedge clk)
        if (rst) dup <= 1'b0;
        else     dup <= dup_n;
`else
    assign repeat_ch = 1'b0;
`endif
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        shadow_n   = shadow;
        ch_out_n   = ch_out;
        ch_valid_n = ch_valid;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                busy_n     = 1'b0;
                ch_valid_n = 1'b0;
                if (start) begin
                    if (str_len == '0) begin
                        state_n = DONE;
                        busy_n  = 1'b1;
                        done_n  = 1'b1;
                    end else if (str_len > MAX_L) begin
                        err_n = 1'b1;
                    end else begin
                        state_n    = SEND;
                        shadow_n   = str_b;
                        idx_n      = len_m1;
                        busy_n     = 1'b1;
                        ch_valid_n = 1'b1;
                        ch_out_n   = str_b[len_m1];
                    end
                end
            end
            SEND: begin
                if (ch_ready && !repeat_ch) begin
                    if (idx == '0) begin
                        state_n    = DONE;
                        ch_valid_n = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        idx_n    = idx_m1;
                        ch_out_n = shadow[idx_m1];
                    end
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            shadow   <= '0;
            ch_out   <= 8'h00;
            ch_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            shadow   <= shadow_n;
            ch_out   <= ch_out_n;
            ch_valid <= ch_valid_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end
endmodule

// File: tb/tb_string_char_sequencer.sv
// tb_string_char_sequencer: directed and random strings checked against a queue-based model of the sent characters.
module tb_string_char_sequencer;
    localparam int MC = 40;
    localparam int LW = 6;
    logic clk = 1'b0;
    logic rst, start, ch_ready, busy, ch_valid, done, err;
    logic [8*MC-1:0] str_in;
    logic [LW-1:0] str_len;
    logic [7:0] ch_out;
    int n_chk = 0;
    int n_fail = 0;

    string_char_sequencer #(.MAX_CHARS(MC), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .str_in(str_in), .str_len(str_len),
        .busy(busy), .ch_out(ch_out), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends s[len], stalling ch_ready for the first `hold` valid cycles, then randomly at rdy_pct.
    task automatic send(input logic [8*MC-1:0] s, input int len, input int hold,
                        input int rdy_pct, input bit disturb);
        byte unsigned q[$];
        int qlen0, stalls, c;
        bit got_done;
        for (int i = len - 1; i >= 0; i--) begin
            byte unsigned b;
            b = s[8*i +: 8];
            q.push_back(b);
`ifdef ESCAPE_DOUBLE_EN
            if (b == 8'h25 || b == 8'h5C) q.push_back(b);
`endif
        end
        qlen0 = q.size();
        stalls = 0;
        got_done = 1'b0;
        str_in = s;
        str_len = LW'(len);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (c = 1; c < 3000 && !got_done; c++) begin
            chk("busy", busy, 1);
            chk("valid", ch_valid, q.size() != 0);
            chk("done", done, q.size() == 0);
            chk("err", err, 0);
            if (q.size() != 0) chk("ch_out", ch_out, q[0]);
            if (disturb) begin
                str_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                str_len = LW'($urandom_range(1, MC));
                start = 1'($urandom_range(0, 1));
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", c, qlen0 + stalls + 1);
            end else begin
                ch_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
                if (hold > 0) hold--;
                if (q.size() != 0) begin
                    if (ch_ready) void'(q.pop_front());
                    else stalls++;
                end
                tick;
            end
        end
        chk("done_seen", got_done, 1);
        start = 1'b0;
        tick;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_valid", ch_valid, 0);
    endtask

    initial begin
        logic [8*MC-1:0] s;
        rst = 1'b1;
        start = 1'b0;
        ch_ready = 1'b1;
        str_in = '0;
        str_len = '0;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_valid", ch_valid, 0);
        chk("rst_out", ch_out, 8'h00);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick;

        s = "Hi";
        send(s, 2, 0, 100, 1'b0);
        send(s, 2, 3, 100, 1'b0);
        send(s, 0, 0, 100, 1'b0);

        for (int l = 41; l <= 63; l += 22) begin
            str_len = LW'(l);
            start = 1'b1;
            tick;
            start = 1'b0;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_valid", ch_valid, 0);
            tick;
            chk("err_clear", err, 0);
            chk("err_nodone", done, 0);
            chk("err_idle", busy, 0);
        end

        s = "Out = in1 + in2";
        send(s, 15, 0, 70, 1'b1);

        s = "Hello World";
        str_in = s;
        str_len = LW'(11);
        ch_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        chk("fifth_char", ch_out, 8'h6F);
        chk("fifth_valid", ch_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_valid", ch_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        tick;
        chk("midrst_nodone", done, 0);
        s = "Hi";
        send(s, 2, 0, 100, 1'b0);

        s = "5%\\";
        send(s, 3, 0, 100, 1'b0);
        send(s, 3, 2, 60, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(1, MC);
            for (int i = 0; i < MC; i++) begin
                case ($urandom_range(0, 5))
                    0: s[8*i +: 8] = 8'h25;
                    1: s[8*i +: 8] = 8'h5C;
                    2: s[8*i +: 8] = 8'h00;
                    default: s[8*i +: 8] = 8'($urandom);
                endcase
            end
            send(s, len, $urandom_range(0, 2), $urandom_range(30, 100), r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
